regfile_write_scheduler: RTL and testbench

Sequencer for the shared register-file write port in the RV32I pipeline. It arbitrates the single write port between the in-order writeback stage and a multi-cycle execution unit (mul/div/long load), using valid/ready handshakes and a bounded-wait fairness counter. It drives the registered `RegWrite`/`rd`/`C` inputs of the register bank. It also keeps a per-register busy scoreboard of outstanding multi-cycle destinations, which the hazard unit uses to stall issue.

---
 rtl/regfile_write_scheduler.sv | 95 +++++++++
 tb/tb_regfile_write_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the register-bank write port between writeback and the multi-cycle unit,
// and tracks outstanding multi-cycle destinations in a busy scoreboard.
module regfile_write_scheduler #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb_valid,
   output logic            wb_ready,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            mc_valid,
   output logic            mc_ready,
   input  logic [4:0]      mc_rd,
   input  logic [XLEN-1:0] mc_data,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   output logic            issue_ready,
   input  logic [4:0]      q_rs1,
   input  logic [4:0]      q_rs2,
   output logic            q_busy1,
   output logic            q_busy2,
   output logic            rf_we,
   output logic [4:0]      rf_rd,
   output logic [XLEN-1:0] rf_wdata
);

   localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

   logic [3:0]  wcnt;
   logic [31:0] busy;
   logic [31:0] busy_nxt;
   logic        rf_src;
   logic        mc_forced;
   logic        wb_hs;
   logic        mc_hs;
   logic        issue_hs;

   // mc wins when starved to the limit, or whenever wb has nothing to offer
   assign mc_forced   = mc_valid && (wcnt == WAIT_LIM);
   assign wb_ready    = wb_valid && !mc_forced;
   assign mc_ready    = mc_valid && (mc_forced || !wb_valid);
   assign wb_hs       = wb_valid && wb_ready;
   assign mc_hs       = mc_valid && mc_ready;

   assign issue_ready = !issue_valid || (issue_rd == 5'd0) || !busy[issue_rd];
   assign issue_hs    = issue_valid && issue_ready;

   assign q_busy1     = busy[q_rs1];
   assign q_busy2     = busy[q_rs2];

   // Clear follows the registered mc write so it lines up with the bank store
   always_comb begin
      busy_nxt = busy;
      if (rf_we && rf_src)
         busy_nxt[rf_rd] = 1'b0;
      if (issue_hs && (issue_rd != 5'd0))
         busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt     <= '0;
         busy     <= '0;
         rf_we    <= 1'b0;
         rf_rd    <= '0;
         rf_wdata <= '0;
         rf_src   <= 1'b0;
      end else begin
         busy <= busy_nxt;

         if (!mc_valid || mc_ready)
            wcnt <= '0;
         else if (wcnt != WAIT_LIM)
            wcnt <= wcnt + 4'd1;

         if (mc_hs) begin
            rf_we    <= (mc_rd != 5'd0);
            rf_rd    <= mc_rd;
            rf_wdata <= mc_data;
            rf_src   <= 1'b1;
         end else if (wb_hs) begin
            rf_we    <= (wb_rd != 5'd0);
            rf_rd    <= wb_rd;
            rf_wdata <= wb_data;
            rf_src   <= 1'b0;
         end else begin
            rf_we    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench: stimulus pushes expected bank writes into a queue, a monitor
// pops and compares them whenever rf_we is presented.
module tb_regfile_write_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid, wb_ready, mc_valid, mc_ready;
   logic [4:0]  wb_rd, mc_rd, issue_rd, q_rs1, q_rs2, rf_rd;
   logic [31:0] wb_data, mc_data, rf_wdata;
   logic        issue_valid, issue_ready, q_busy1, q_busy2, rf_we;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   wr_t expq[$];
   int  vectors     = 0;
   int  miscompares = 0;

   regfile_write_scheduler #(.XLEN(32), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
      .q_rs1(q_rs1), .q_rs2(q_rs2), .q_busy1(q_busy1), .q_busy2(q_busy2),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Registered outputs are stable at the falling edge.
   always @(negedge clk) begin
      if (rst === 1'b0 && rf_we === 1'b1) begin
         if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got rd %0d data %0h, expected no write", rf_rd, rf_wdata);
         end else begin
            wr_t e;
            e = expq.pop_front();
            chk("wr_rd", 32'(rf_rd), 32'(e.rd));
            chk("wr_data", rf_wdata, e.data);
         end
      end
   end

   task automatic step(input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                       input logic mcv, input logic [4:0] mcrd, input logic [31:0] mcd,
                       input logic iv, input logic [4:0] ird,
                       input logic ewb, input logic emc, input logic eis);
      @(negedge clk);
      wb_valid = wbv; wb_rd = wbrd; wb_data = wbd;
      mc_valid = mcv; mc_rd = mcrd; mc_data = mcd;
      issue_valid = iv; issue_rd = ird;
      #1;
      chk("wb_ready", 32'(wb_ready), 32'(ewb));
      chk("mc_ready", 32'(mc_ready), 32'(emc));
      chk("issue_ready", 32'(issue_ready), 32'(eis));
      if (mcv && emc && mcrd != 5'd0)
         expq.push_back('{rd: mcrd, data: mcd});
      else if (wbv && ewb && wbrd != 5'd0)
         expq.push_back('{rd: wbrd, data: wbd});
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, expected finish before 100000");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      wb_valid = 0; wb_rd = 0; wb_data = 0;
      mc_valid = 0; mc_rd = 0; mc_data = 0;
      issue_valid = 0; issue_rd = 0; q_rs1 = 5'd7; q_rs2 = 5'd3;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_rf_rd", 32'(rf_rd), 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_issue_ready", 32'(issue_ready), 32'd1);
      chk("rst_q_busy1", 32'(q_busy1), 32'd0);
      chk("rst_q_busy2", 32'(q_busy2), 32'd0);
      chk("rst_wb_ready", 32'(wb_ready), 32'd0);
      chk("rst_mc_ready", 32'(mc_ready), 32'd0);

      // Single writeback
      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
      idle(2);

      // Fairness: mc wins on cycles 4, 9, 14
      for (int i = 0; i < 15; i++) begin
         logic m;
         m = (i == 4) || (i == 9) || (i == 14);
         step(1'b1, 5'(i + 1), 32'h1000 + 32'(i), 1'b1, 5'd10, 32'hA000 + 32'(i),
              1'b0, 5'd0, !m, m, 1'b1);
      end
      idle(2);

      // Scoreboard on rd 7
      q_rs1 = 5'd7; q_rs2 = 5'd3;
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
      chk("busy7_set", 32'(q_busy1), 32'd1);
      chk("busy3_clear", 32'(q_busy2), 32'd0);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      chk("busy7_at_hs", 32'(q_busy1), 32'd1);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
      chk("busy7_after_E0", 32'(q_busy1), 32'd1);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
      chk("busy7_after_E1", 32'(q_busy1), 32'd0);
      idle(1);
      chk("busy7_reissued", 32'(q_busy1), 32'd1);

      // Clear of 7 and set of 9 on the same edge
      q_rs2 = 5'd9;
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h34, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
      idle(1);
      chk("busy7_cleared", 32'(q_busy1), 32'd0);
      chk("busy9_set", 32'(q_busy2), 32'd1);

      // rd 0 handshakes never write or mark busy
      step(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
      chk("rd0_no_we", 32'(rf_we), 32'd0);
      q_rs1 = 5'd0;
      idle(1);
      chk("rd0_busy", 32'(q_busy1), 32'd0);
      chk("rd0_busy9_kept", 32'(q_busy2), 32'd1);

      // Build wcnt to 2, then async reset in the cycle after a handshake
      step(1'b1, 5'd12, 32'hCAFE, 1'b1, 5'd10, 32'hB0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 5'd13, 32'hBEEF, 1'b1, 5'd10, 32'hB1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      wb_valid = 0; mc_valid = 0; issue_valid = 0;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_we", 32'(rf_we), 32'd0);
      @(posedge clk); #1;
      chk("rst_hold_we", 32'(rf_we), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_rf_rd", 32'(rf_rd), 32'd0);
      chk("post_rst_rf_wdata", rf_wdata, 32'd0);
      chk("post_rst_busy9", 32'(q_busy2), 32'd0);

      // Counter cleared by reset: mc wins again only at cycle 4
      for (int i = 0; i < 5; i++) begin
         logic m;
         m = (i == 4);
         step(1'b1, 5'd20, 32'h2000 + 32'(i), 1'b1, 5'd21, 32'h3000 + 32'(i),
              1'b0, 5'd0, !m, m, 1'b1);
      end
      idle(3);

      chk("pending_writes", 32'(expq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
